fifo_checker: RTL
=================

FIFO_CHECKER -- requirements
Module: fifo_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 8: FIFO data width.
REQ-002 SHALL have parameter CNT_W, default 8: error counter width.
REQ-003 SHALL have parameter TIME_W, default 16: cycle-stamp width.
REQ-004 SHALL have parameter ALIGN, default 0, range 0..3: golden-input delay in cycles.
REQ-005 SHALL have parameter MASK_EMPTY, default 1: when 1, data is not compared while both EMPTY flags are high.
REQ-006 SHALL have one clock and an asynchronous, active-high reset: SYSCLK in 1 (rising edge), RST in 1.
REQ-007 SHALL have ports: CHK_EN in 1 (checking enable); CLR in 1 (synchronous clear of results).
REQ-008 SHALL have ports: FIFO_OUT in DATA_W; EMPTY in 1; FULL in 1 (these are the DUT outputs).
REQ-009 SHALL have ports: FIFO_OUT_G in DATA_W; EMPTY_G in 1; FULL_G in 1 (these are the golden-model outputs).
REQ-010 SHALL have ports: ERROR out 1 (sticky fail); ERR_COUNT out CNT_W; ERR_FLAGS out DATA_W+2 (last-cycle mismatch vector).
REQ-011 SHALL have ports: FIRST_ERR_TIME out TIME_W; FIRST_ERR_VEC out DATA_W+2; STATE out 2.

Function
REQ-012 SHALL delay the golden inputs by ALIGN registered stages before comparison; with ALIGN=0 the comparison is combinational on the current inputs.
REQ-013 SHALL form the mismatch vector {FIFO_OUT,EMPTY,FULL} ^ {aligned golden}, with the data bits forced to 0 when MASK_EMPTY=1 and both EMPTY flags are 1.
REQ-014 SHALL sample the mismatch vector into ERR_FLAGS each cycle while the checker is in ARMED or FAILED; otherwise ERR_FLAGS SHALL be 0.
REQ-015 SHALL implement states IDLE=0, WARMUP=1, ARMED=2, FAILED=3, output on STATE.
REQ-016 SHALL transition IDLE->WARMUP when CHK_EN=1; WARMUP lasts ALIGN cycles, then goes to ARMED (with ALIGN=0, WARMUP lasts 1 cycle); no comparison is made in WARMUP.
REQ-017 SHALL transition ARMED->FAILED on the first cycle with a nonzero mismatch vector.
REQ-018 SHALL remain in FAILED until CLR or RST.
REQ-019 SHALL return to IDLE from any state when CHK_EN=0, retaining ERROR, ERR_COUNT and the FIRST_ERR_* values.
REQ-020 SHALL increment ERR_COUNT by 1 per mismatching cycle in ARMED or FAILED, saturating at all-ones with no wrap.
REQ-021 SHALL run a cycle counter that clears on entry to ARMED, increments each ARMED or FAILED cycle, and saturates at all-ones.
REQ-022 SHALL, on the first mismatch only, capture the cycle counter into FIRST_ERR_TIME and the mismatch vector into FIRST_ERR_VEC; later mismatches SHALL NOT overwrite them.
REQ-023 SHALL assert ERROR in the cycle after the first mismatch and hold it (sticky).
REQ-024 SHALL give CLR priority over a same-cycle mismatch: all results clear, nothing is counted, and the next state is WARMUP if CHK_EN=1, else IDLE.
REQ-025 SHALL give all outputs a latency of 1 cycle from the compared inputs to the registered result.

Reset
REQ-026 SHALL, while RST=1 and asynchronously, force STATE=IDLE, all outputs to 0, and the alignment pipeline and cycle counter to 0.
REQ-027 SHALL, when RST is asserted mid-check, discard all results with no partial count retained; checking resumes through WARMUP after RST deasserts.

Configuration
REQ-028 SHALL, with FIFO_CHECKER_DISPLAY_EN defined, print one line per counted mismatch giving $time, the mismatch vector and the updated ERR_COUNT, plus one line on IDLE entry summarising the count.
REQ-029 SHALL, without FIFO_CHECKER_DISPLAY_EN, contain no system tasks and be fully synthesizable; port-level behaviour SHALL be identical with or without the macro.

Structure
REQ-030 SHALL place the state encoding localparams and the ALIGN range limit in the shared package fifo_chk_pkg.
REQ-031 SHALL implement the golden alignment delay as the sub-module fifo_chk_align (parameters DATA_W and ALIGN).

Verification
REQ-032 SHALL cover: ALIGN=0, identical streams for 100 cycles -> ERROR=0, ERR_COUNT=0, STATE=2.
REQ-033 SHALL cover: FIFO_OUT=8'h5A vs FIFO_OUT_G=8'h5B at armed cycle 7 -> ERR_FLAGS=10'h004, FIRST_ERR_TIME=7, ERR_COUNT=1, ERROR=1, STATE=3.
REQ-034 SHALL cover: 300 consecutive mismatches with CNT_W=8 -> ERR_COUNT saturates at 255, and FIRST_ERR_VEC keeps its first value.
REQ-035 SHALL cover: EMPTY=EMPTY_G=1 with differing data and MASK_EMPTY=1 -> no error; repeated with MASK_EMPTY=0 -> ERR_COUNT=1.
REQ-036 SHALL cover: ALIGN=2 with the golden stream driven 2 cycles early -> no errors; then CLR in the same cycle as a mismatch -> ERR_COUNT=0 and STATE=1.
REQ-037 SHALL cover: RST pulse mid-FAILED -> all outputs 0 immediately, asynchronously; after release, STATE sequences 0->1->2.

Source files
------------

// File: rtl/fifo_chk_pkg.sv
// Shared definitions for the FIFO checker: state encoding, alignment limit.
package fifo_chk_pkg;

    typedef logic [1:0] chk_state_t;

    localparam chk_state_t ST_IDLE   = 2'd0;
    localparam chk_state_t ST_WARMUP = 2'd1;
    localparam chk_state_t ST_ARMED  = 2'd2;
    localparam chk_state_t ST_FAILED = 2'd3;

    // Deepest golden-alignment pipeline supported
    localparam int ALIGN_MAX = 3;

endpackage

// File: rtl/fifo_checker_if.sv
// Compared FIFO streams: DUT outputs and golden-model outputs.
// master drives the streams, slave (the checker) observes them.
interface fifo_checker_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] FIFO_OUT;
    logic              EMPTY;
    logic              FULL;
    logic [DATA_W-1:0] FIFO_OUT_G;
    logic              EMPTY_G;
    logic              FULL_G;

    modport master (output FIFO_OUT, EMPTY, FULL, FIFO_OUT_G, EMPTY_G, FULL_G);
    modport slave  (input  FIFO_OUT, EMPTY, FULL, FIFO_OUT_G, EMPTY_G, FULL_G);
endinterface

// File: rtl/fifo_chk_align.sv
// Delays the golden vector {data, empty, full} by ALIGN register stages.
// ALIGN=0 is a straight wire; values above ALIGN_MAX are clamped.
module fifo_chk_align
    import fifo_chk_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ALIGN  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W+1:0] vec_i,
    output logic [DATA_W+1:0] vec_o
);
    localparam int DEPTH = (ALIGN > ALIGN_MAX) ? ALIGN_MAX : ALIGN;

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst};
            assign vec_o = vec_i;
        end else begin : g_pipe
            logic [DATA_W+1:0] stage_q [DEPTH];

            // Shift register of golden samples, cleared by reset
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= vec_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign vec_o = stage_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/fifo_checker.sv
// FIFO checker: compares DUT FIFO outputs against an aligned golden model,
// tracks sticky failure, saturating error count and first-error capture.
// Optional macro FIFO_CHECKER_DISPLAY_EN adds simulation-only mismatch logging.
module fifo_checker
    import fifo_chk_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 8,
    parameter int TIME_W     = 16,
    parameter int ALIGN      = 0,
    parameter int MASK_EMPTY = 1
) (
    input  logic                SYSCLK,
    input  logic                RST,
    input  logic                CHK_EN,
    input  logic                CLR,
    fifo_checker_if.slave       fifo,
    output logic                ERROR,
    output logic [CNT_W-1:0]    ERR_COUNT,
    output logic [DATA_W+1:0]   ERR_FLAGS,
    output logic [TIME_W-1:0]   FIRST_ERR_TIME,
    output logic [DATA_W+1:0]   FIRST_ERR_VEC,
    output logic [1:0]          STATE
);
    localparam int         VEC_W     = DATA_W + 2;
    localparam int         DEPTH     = (ALIGN > ALIGN_MAX) ? ALIGN_MAX : ALIGN;
    localparam int         WARM_LEN  = (DEPTH == 0) ? 1 : DEPTH;
    localparam logic [1:0] WARM_LAST = 2'(WARM_LEN - 1);

    logic [VEC_W-1:0]  gold_vec, gold_aligned, dut_vec, mis_vec;
    chk_state_t        state_q, state_d;
    logic [1:0]        warm_q, warm_d;
    logic              cmp_act, counted, arm_entry;

    logic              error_q, error_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [VEC_W-1:0]  err_flags_q, err_flags_d;
    logic [TIME_W-1:0] first_time_q, first_time_d;
    logic [VEC_W-1:0]  first_vec_q, first_vec_d;
    logic [TIME_W-1:0] cyc_q, cyc_d;

    assign gold_vec = {fifo.FIFO_OUT_G, fifo.EMPTY_G, fifo.FULL_G};
    assign dut_vec  = {fifo.FIFO_OUT, fifo.EMPTY, fifo.FULL};

    fifo_chk_align #(.DATA_W(DATA_W), .ALIGN(DEPTH)) u_align (
        .clk   (SYSCLK),
        .rst   (RST),
        .vec_i (gold_vec),
        .vec_o (gold_aligned)
    );

    // Mismatch vector; data bits ignored while both sides report empty
    always_comb begin
        mis_vec = dut_vec ^ gold_aligned;
        if (MASK_EMPTY != 0 && fifo.EMPTY && gold_aligned[1]) mis_vec[VEC_W-1:2] = '0;
    end

    // State register and warm-up counter
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
        end
    end

    // Next state: disable beats clear, clear beats any mismatch
    always_comb begin
        state_d = state_q;
        warm_d  = '0;
        if (!CHK_EN) begin
            state_d = ST_IDLE;
        end else if (CLR) begin
            state_d = ST_WARMUP;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_WARMUP;
                ST_WARMUP: begin
                    if (warm_q == WARM_LAST) state_d = ST_ARMED;
                    else                     warm_d  = warm_q + 2'd1;
                end
                ST_ARMED:  if (|mis_vec) state_d = ST_FAILED;
                default:   state_d = ST_FAILED;
            endcase
        end
    end

    // Per-cycle decode of the current state
    always_comb begin
        cmp_act   = (state_q == ST_ARMED) || (state_q == ST_FAILED);
        counted   = cmp_act && !CLR && (|mis_vec);
        arm_entry = (state_q == ST_WARMUP) && (state_d == ST_ARMED);
    end

    // Result next-state: clear, count, first-error capture, cycle stamp
    always_comb begin
        error_d      = error_q;
        err_count_d  = err_count_q;
        err_flags_d  = '0;
        first_time_d = first_time_q;
        first_vec_d  = first_vec_q;
        cyc_d        = cyc_q;
        if (CLR) begin
            error_d      = 1'b0;
            err_count_d  = '0;
            first_time_d = '0;
            first_vec_d  = '0;
            cyc_d        = '0;
        end else begin
            if (cmp_act) err_flags_d = mis_vec;
            if (counted) begin
                error_d = 1'b1;
                if (!(&err_count_q)) err_count_d = err_count_q + 1'b1;
                if (!error_q) begin
                    first_time_d = cyc_q;
                    first_vec_d  = mis_vec;
                end
            end
            if (arm_entry)                     cyc_d = '0;
            else if (cmp_act && !(&cyc_q))     cyc_d = cyc_q + 1'b1;
        end
    end

    // Result registers
    always_ff @(posedge SYSCLK or posedge RST) begin
        if (RST) begin
            error_q      <= 1'b0;
            err_count_q  <= '0;
            err_flags_q  <= '0;
            first_time_q <= '0;
            first_vec_q  <= '0;
            cyc_q        <= '0;
        end else begin
            error_q      <= error_d;
            err_count_q  <= err_count_d;
            err_flags_q  <= err_flags_d;
            first_time_q <= first_time_d;
            first_vec_q  <= first_vec_d;
            cyc_q        <= cyc_d;
        end
    end

    assign ERROR          = error_q;
    assign ERR_COUNT      = err_count_q;
    assign ERR_FLAGS      = err_flags_q;
    assign FIRST_ERR_TIME = first_time_q;
    assign FIRST_ERR_VEC  = first_vec_q;
    assign STATE          = state_q;

`ifdef FIFO_CHECKER_DISPLAY_EN
    // Log each counted mismatch and a summary on every return to IDLE
    always @(posedge SYSCLK) begin
        if (!RST && counted)
            $display("%0t fifo_checker: mismatch vec=%h err_count=%0d", $time, mis_vec, err_count_d);
        if (!RST && state_q != ST_IDLE && state_d == ST_IDLE)
            $display("%0t fifo_checker: idle, err_count=%0d", $time, err_count_d);
    end
`endif

endmodule
